// File: rtl/mem_lsu_if.sv
// Data-memory port: request/grant handshake plus a response valid strobe.
interface mem_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus transaction per memory instruction,
// pipeline stalled until the access (or its misalignment trap) completes.
module mem_lsu (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    funct3,
  input  logic [31:0]   addr,
  input  logic [31:0]   store_data,
  mem_lsu_if.master     dmem,
  output logic          stall,
  output logic [31:0]   load_data,
  output logic          misaligned,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_n;
  logic        mem_op, is_ld, sz_ok, trap;
  logic        accept, capture, stall_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [1:0]  off_q;
  logic        ld_q;

  assign mem_op = ex_valid & (mem_read | mem_write);
  // a load wins when both read and write are asserted
  assign is_ld  = mem_read;
  // stores only define widths 000..010; loads use funct3[2] as the unsigned flag
  assign sz_ok  = is_ld | ~funct3[2];
  assign trap   = sz_ok & (((funct3[1:0] == 2'b01) & addr[0]) |
                           ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));

  // byte enables and lane-replicated data for the incoming store
  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = 32'h0;
    if (!is_ld && sz_ok) begin
      case (funct3[1:0])
        2'b00: begin
          wstrb_c = 4'b0001 << addr[1:0];
          wdata_c = {4{store_data[7:0]}};
        end
        2'b01: begin
          wstrb_c = 4'b0011 << {addr[1], 1'b0};
          wdata_c = {2{store_data[15:0]}};
        end
        2'b10: begin
          wstrb_c = 4'b1111;
          wdata_c = store_data;
        end
        default: begin
          wstrb_c = 4'b0000;
          wdata_c = store_data;
        end
      endcase
    end
  end

  // next state, stall and the accept/capture strobes
  always_comb begin
    state_n = state;
    stall_c = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: if (mem_op) begin
        stall_c = 1'b1;
        accept  = 1'b1;
        state_n = trap ? DONE : REQ;
      end
      REQ: begin
        stall_c = 1'b1;
        if (dmem.dmem_gnt) begin
          if (dmem.dmem_rvalid) begin
            capture = 1'b1;
            state_n = DONE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (dmem.dmem_rvalid) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // stall must read low while reset is held, whatever the pipeline presents
  assign stall = stall_c & ~rst;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // bus outputs are registered so they stay stable for the whole REQ phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wstrb <= 4'b0000;
      dmem.dmem_wdata <= 32'h0;
      off_q           <= 2'b00;
      ld_q            <= 1'b0;
    end else begin
      dmem.dmem_req <= (state_n == REQ);
      if (accept) begin
        dmem.dmem_we    <= ~is_ld;
        dmem.dmem_addr  <= {addr[31:2], 2'b00};
        dmem.dmem_wstrb <= wstrb_c;
        dmem.dmem_wdata <= wdata_c;
        off_q           <= addr[1:0];
        ld_q            <= is_ld;
      end
    end
  end

  // completion pulses and right-justified load capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= 32'h0;
    end else begin
      done       <= (state_n == DONE);
      misaligned <= accept & trap;
      if (capture && ld_q)
        load_data <= dmem.dmem_rdata >> {off_q, 3'b000};
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a width/offset model predicts bus fields,
// cycle counts and load results; a responder plays the memory side.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, misaligned, done;
  logic [31:0] load_data;

  mem_lsu_if bus();

  mem_lsu dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .store_data(store_data), .dmem(bus), .stall(stall),
    .load_data(load_data), .misaligned(misaligned), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  bit          chk_en = 1'b0;
  logic [31:0] ld_model = 32'h0;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic        exp_we, exp_trap;

  // snapshot of the last transaction for literal checks
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_wstrb;
  logic        last_we, last_mis;
  int          last_stalls, last_nreq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // every cycle: bus fields while requesting, held load data when not stalled
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      if (bus.dmem_req) begin
        chk("req_addr", bus.dmem_addr, exp_addr);
        chk("req_we", {31'b0, bus.dmem_we}, {31'b0, exp_we});
        chk("req_wstrb", {28'b0, bus.dmem_wstrb}, {28'b0, exp_wstrb});
        if (exp_wstrb != 4'b0000)
          chk("req_wdata", bus.dmem_wdata, exp_wdata);
      end
      if (!stall)
        chk("load_data_held", load_data, ld_model);
    end
  end

  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int gdly, input int rdly, input logic [31:0] rdata);
    int sz, base, rq, since, stalls, nreq, cyc;
    bit granted, got_done, rv_now;
    logic [31:0] ld_val;
    // model: access size in bytes from the width code
    if (rd) sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    else    sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    exp_trap = (sz > 1) && ((a % sz) != 0);
    exp_addr = a - (a % 4);
    exp_we   = !rd;
    exp_wstrb = 4'b0000;
    exp_wdata = 32'h0;
    if (!rd && sz != 0) begin
      base = int'(a % 4) - int'(a % sz);
      for (int i = 0; i < 4; i++) begin
        exp_wstrb[i] = (i >= base) && (i < base + sz);
        exp_wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
      end
    end
    ld_val = rdata >> (8 * (a % 4));

    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    addr = a; store_data = sd;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = rdata;
    rq = 0; since = 0; stalls = 0; nreq = 0; cyc = 0;
    granted = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (stall) stalls++;
      if (bus.dmem_req) begin
        nreq++;
        last_addr = bus.dmem_addr; last_we = bus.dmem_we;
        last_wstrb = bus.dmem_wstrb; last_wdata = bus.dmem_wdata;
      end
      if (done) begin
        got_done = 1'b1;
        last_mis = misaligned;
        chk("misaligned", {31'b0, misaligned}, {31'b0, exp_trap});
      end
      @(posedge clk);
      rv_now = bus.dmem_rvalid;
      if (rv_now && rd) ld_model = ld_val;
      #1;
      if (got_done) begin
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
      end else if (bus.dmem_req) begin
        rq++;
        bus.dmem_gnt = (rq == gdly + 1);
        if (bus.dmem_gnt) begin
          granted = 1'b1;
          bus.dmem_rvalid = (rdly == 0);
        end else begin
          bus.dmem_rvalid = 1'b0;
        end
      end else begin
        bus.dmem_gnt = 1'b0;
        if (granted) since++;
        bus.dmem_rvalid = granted && (since == rdly);
      end
    end
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
    last_stalls = stalls; last_nreq = nreq;
    chk("stall_cycles", stalls, exp_trap ? 1 : 2 + gdly + rdly);
    chk("req_cycles", nreq, exp_trap ? 0 : gdly + 1);
    // cycle after DONE: pulses gone, pipeline free
    @(negedge clk);
    chk("done_pulse_end", {31'b0, done}, 32'd0);
    chk("mis_pulse_end", {31'b0, misaligned}, 32'd0);
    chk("stall_idle", {31'b0, stall}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'd0; addr = 32'h0; store_data = 32'h0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    ex_valid = 1'b1; mem_read = 1'b1;  // stall must still read 0 in reset
    @(negedge clk);
    chk("rst_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_load", load_data, 32'h0);
    ex_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    chk_en = 1'b1;

    // LW 0x100, grant+response in first REQ cycle
    run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    chk("lw_addr", last_addr, 32'h100);
    chk("lw_wstrb", {28'b0, last_wstrb}, 32'h0);
    chk("lw_stalls", last_stalls, 2);
    chk("lw_data", load_data, 32'hDEADBEEF);

    // LB 0x103, grant after 3 waits, response 2 cycles later
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 3, 2, 32'h80112233);
    chk("lb_req_cycles", last_nreq, 4);
    chk("lb_data", load_data, 32'h00000080);

    // SB 0x202
    run_op(0, 1, 3'b000, 32'h202, 32'h000000A5, 0, 1, 32'hFFFFFFFF);
    chk("sb_addr", last_addr, 32'h200);
    chk("sb_wstrb", {28'b0, last_wstrb}, 32'h4);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
    chk("sb_we", {31'b0, last_we}, 32'd1);
    chk("sb_keep_load", load_data, 32'h00000080);

    // SH 0x306
    run_op(0, 1, 3'b001, 32'h306, 32'h1234BEEF, 1, 0, 32'h0);
    chk("sh_wstrb", {28'b0, last_wstrb}, 32'hC);
    chk("sh_wdata", last_wdata, 32'hBEEFBEEF);

    // LW 0x101 traps
    run_op(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11111111);
    chk("lwmis_nreq", last_nreq, 0);
    chk("lwmis_stalls", last_stalls, 1);
    chk("lwmis_flag", {31'b0, last_mis}, 32'd1);
    chk("lwmis_keep_load", load_data, 32'h00000080);

    // assorted widths and corner encodings
    run_op(0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 0, 1, 32'h0);
    run_op(0, 1, 3'b011, 32'h404, 32'h55AA55AA, 2, 1, 32'h0);
    chk("sinv_wstrb", {28'b0, last_wstrb}, 32'h0);
    run_op(1, 1, 3'b101, 32'h10A, 32'h0, 1, 3, 32'hAABBCCDD);
    chk("lhu_data", load_data, 32'h0000AABB);
    run_op(1, 0, 3'b001, 32'h10B, 32'h0, 0, 0, 32'h0);
    run_op(0, 1, 3'b001, 32'h201, 32'h1234, 0, 0, 32'h0);

    // stray response while idle
    @(posedge clk); #1 bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h77777777;
    @(posedge clk); #1 bus.dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("idle_rvalid_load", load_data, 32'h0000AABB);
    chk("idle_rvalid_done", {31'b0, done}, 32'd0);

    // reset while waiting for a response
    chk_en = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1 bus.dmem_gnt = 1'b1;
    @(posedge clk); #1 bus.dmem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_stall", {31'b0, stall}, 32'd1);
    chk("wait_noreq", {31'b0, bus.dmem_req}, 32'd0);
    @(posedge clk); #1 rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0;
    #1;
    chk("mrst_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("mrst_stall", {31'b0, stall}, 32'd0);
    chk("mrst_load", load_data, 32'h0);
    chk("mrst_addr", bus.dmem_addr, 32'h0);
    ld_model = 32'h0;
    @(posedge clk); #1 rst = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
    @(posedge clk); #1 bus.dmem_rvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid_load", load_data, 32'h0);
    chk("post_rst_rvalid_done", {31'b0, done}, 32'd0);
    chk_en = 1'b1;
    run_op(1, 0, 3'b010, 32'h500, 32'h0, 0, 1, 32'h0BADF00D);
    chk("fresh_lw_data", load_data, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
